// File: rtl/cv_ctrl_ports.sv
// cv_ctrl_ports: ColecoVision controller-port engine for NPORTS ports.
// It sits between the MiSTer joystick vectors and cv_console. Joystick
// vectors and the p5/p8 selects are sampled on ce_i. The keypad/joystick
// nibble and the fire line are driven from a second ce_i register stage.
// Build option CV_SPINNER_EN adds Super Action / Roller Controller spinner
// emulation. Signed motion deltas are accumulated and replayed as
// rate-limited quadrature on p7/p9. Without the option, p7/p9 are tied high.
// ACC_W must be at least 8 so a full 8-bit delta fits the accumulator sum.

module cv_ctrl_ports #(
  parameter int NPORTS   = 2,
  parameter int SPIN_DIV = 1070,
  parameter int ACC_W    = 10
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic                 ce_i,
  input  logic [20*NPORTS-1:0] joy_i,
  input  logic [8*NPORTS-1:0]  spin_delta_i,
  input  logic [NPORTS-1:0]    spin_stb_i,
  input  logic [NPORTS-1:0]    ctrl_p5_i,
  input  logic [NPORTS-1:0]    ctrl_p8_i,
  output logic [NPORTS-1:0]    ctrl_p1_o,
  output logic [NPORTS-1:0]    ctrl_p2_o,
  output logic [NPORTS-1:0]    ctrl_p3_o,
  output logic [NPORTS-1:0]    ctrl_p4_o,
  output logic [NPORTS-1:0]    ctrl_p6_o,
  output logic [NPORTS-1:0]    ctrl_p7_o,
  output logic [NPORTS-1:0]    ctrl_p9_o
);

  // Legend code of the highest-priority pressed key: 0..9, *, #, purple, blue.
  function automatic logic [3:0] keypad_code(input logic [19:0] j);
    logic [3:0] code;
    if      (j[8])  code = 4'b0011;  // 0
    else if (j[9])  code = 4'b1110;  // 1
    else if (j[10]) code = 4'b1101;  // 2
    else if (j[11]) code = 4'b0110;  // 3
    else if (j[12]) code = 4'b0001;  // 4
    else if (j[13]) code = 4'b1001;  // 5
    else if (j[14]) code = 4'b0111;  // 6
    else if (j[15]) code = 4'b1100;  // 7
    else if (j[16]) code = 4'b1000;  // 8
    else if (j[17]) code = 4'b1011;  // 9
    else if (j[6])  code = 4'b1010;  // *
    else if (j[7])  code = 4'b0101;  // #
    else if (j[18]) code = 4'b0100;  // purple
    else if (j[19]) code = 4'b0010;  // blue
    else            code = 4'b1111;  // nothing pressed
    return code;
  endfunction

  // {p1,p2,p3,p4,p6} for one port. An unselected leg contributes all ones,
  // so ANDing both legs covers the single-leg, both-legs and idle cases.
  function automatic logic [4:0] port_lines(input logic [19:0] j,
                                            input logic sel5, input logic sel8);
    logic [4:0] kp;
    logic [4:0] js;
    kp = sel5 ? 5'b11111 : {keypad_code(j), ~j[5]};
    js = sel8 ? 5'b11111 : {~j[3], ~j[2], ~j[1], ~j[0], ~j[4]};
    return kp & js;
  endfunction

  logic [20*NPORTS-1:0] joy_q;
  logic [NPORTS-1:0]    sel5_q;
  logic [NPORTS-1:0]    sel8_q;
  logic [4:0]           lines [NPORTS];

  // Input sample stage: capture joystick vectors and selects on each ce tick.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      joy_q  <= '0;
      sel5_q <= '1;
      sel8_q <= '1;
    end else if (ce_i) begin
      // NOTE: non-blocking assignments keep every register reading the
      // pre-edge value of its sources, whatever the statement order.
      joy_q  <= joy_i;
      sel5_q <= ctrl_p5_i;
      sel8_q <= ctrl_p8_i;
    end
  end

  // Decode each port's sampled state into its pin levels.
  always_comb begin
    for (int p = 0; p < NPORTS; p++) begin
      lines[p] = port_lines(joy_q[20*p +: 20], sel5_q[p], sel8_q[p]);
    end
  end

  // Output stage: register the decoded pin levels on the next ce tick.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      ctrl_p1_o <= '1;
      ctrl_p2_o <= '1;
      ctrl_p3_o <= '1;
      ctrl_p4_o <= '1;
      ctrl_p6_o <= '1;
    end else if (ce_i) begin
      for (int p = 0; p < NPORTS; p++) begin
        ctrl_p1_o[p] <= lines[p][4];
        ctrl_p2_o[p] <= lines[p][3];
        ctrl_p3_o[p] <= lines[p][2];
        ctrl_p4_o[p] <= lines[p][1];
        ctrl_p6_o[p] <= lines[p][0];
      end
    end
  end

`ifdef CV_SPINNER_EN
  // Quadrature phase as {p7,p9}. Positive motion walks 11->10->00->01->11.
  typedef enum logic [1:0] {
    PH_11 = 2'b11,
    PH_10 = 2'b10,
    PH_00 = 2'b00,
    PH_01 = 2'b01
  } phase_t;

  localparam int CNT_W = (SPIN_DIV > 1) ? $clog2(SPIN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(SPIN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam int ACC_LIM = (1 << (ACC_W - 1)) - 1;
  localparam logic signed [ACC_W+1:0] SUM_MAX = (ACC_W+2)'(ACC_LIM);
  localparam logic signed [ACC_W+1:0] SUM_MIN = (ACC_W+2)'(-ACC_LIM);
  localparam logic signed [ACC_W+1:0] SUM_ONE = (ACC_W+2)'(1);
  localparam logic signed [ACC_W-1:0] ACC_MAX = ACC_W'(ACC_LIM);
  localparam logic signed [ACC_W-1:0] ACC_MIN = ACC_W'(-ACC_LIM);

  // One quadrature step forward (positive motion) or backward.
  function automatic phase_t quad_next(input phase_t ph, input logic fwd);
    phase_t nx;
    case (ph)
      PH_11:   nx = fwd ? PH_10 : PH_01;
      PH_10:   nx = fwd ? PH_00 : PH_11;
      PH_00:   nx = fwd ? PH_01 : PH_10;
      default: nx = fwd ? PH_11 : PH_00;
    endcase
    return nx;
  endfunction

  for (genvar p = 0; p < NPORTS; p++) begin : g_spin
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic signed [ACC_W+1:0] sum;
    logic [CNT_W-1:0]        cnt;
    logic [CNT_W-1:0]        cnt_next;
    phase_t                  phase;
    phase_t                  phase_next;
    logic                    reload;
    logic                    step;

    assign reload = ce_i && (cnt == '0);
    assign step   = reload && (acc != '0);

    // Accumulate strobed deltas, drain one count per step, saturate.
    always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves one unassigned and no latch is inferred.
      cnt_next   = cnt;
      phase_next = phase;
      acc_next   = acc;
      sum        = {{2{acc[ACC_W-1]}}, acc};
      if (ce_i) begin
        cnt_next = reload ? CNT_RELOAD : cnt - CNT_ONE;
      end
      if (spin_stb_i[p]) begin
        sum = sum + {{(ACC_W-6){spin_delta_i[8*p+7]}}, spin_delta_i[8*p +: 8]};
      end
      if (step) begin
        phase_next = quad_next(phase, !acc[ACC_W-1]);
        sum        = acc[ACC_W-1] ? sum + SUM_ONE : sum - SUM_ONE;
      end
      if (sum > SUM_MAX)      acc_next = ACC_MAX;
      else if (sum < SUM_MIN) acc_next = ACC_MIN;
      else                    acc_next = sum[ACC_W-1:0];
    end

    // Spinner state registers; reset discards any pending motion.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
        acc   <= '0;
        cnt   <= '0;
        phase <= PH_11;
      end else begin
        acc   <= acc_next;
        cnt   <= cnt_next;
        phase <= phase_next;
      end
    end

    assign ctrl_p7_o[p] = phase[1];
    assign ctrl_p9_o[p] = phase[0];
  end
`else
  // Spinner absent: quadrature pins idle high and motion inputs are ignored.
  logic unused_spin;
  assign unused_spin = ^{spin_delta_i, spin_stb_i};
  assign ctrl_p7_o   = '1;
  assign ctrl_p9_o   = '1;
`endif

endmodule
